// File: rtl/fetch_stage.sv
// Instruction fetch stage: 8-bit PC, combinational imem lookup and a registered IF/ID slot.
// Define FETCH_HALT_ON_ZERO_EN to stop fetching on an all-zero instruction word.
module fetch_stage #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [7:0]  dec_pc,
  output logic        halted
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  dpc_q, dpc_d;
  logic        advance;
  logic        halt_hit;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign halt_hit = (imem_instr == 32'h0);
  assign halted   = (state_q == StHalt);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  assign advance = (!valid_q || dec_ready) && !redirect_valid && (state_q == StRun);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    dpc_d   = dpc_q;
    if (redirect_valid) begin
      // Redirect flushes the slot regardless of dec_ready and always resumes fetching.
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = StRun;
    end else if (advance) begin
      if (halt_hit) begin
        state_d = StHalt;
        valid_d = 1'b0;
      end else begin
        instr_d = imem_instr;
        dpc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 8'd1;
      end
    end else if (valid_q && dec_ready) begin
      // Only reachable while halted: drain the last instruction, nothing replaces it.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      dpc_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      dpc_q   <= dpc_d;
    end
  end

  assign imem_addr = pc_q;
  assign dec_valid = valid_q;
  assign dec_instr = instr_q;
  assign dec_pc    = dpc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, corner sequences and a random run
// checked against a transaction-level model of the fetch rules.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [7:0]  dec_pc;
  logic        halted;

  logic [31:0] mem [256];

  int n_vec;
  int n_err;

  // Reference state: what the outputs must show after the next clock edge.
  logic        m_valid;
  logic [31:0] m_instr;
  logic [7:0]  m_dpc;
  logic [7:0]  m_pc;
  logic        m_halt;

  typedef struct {
    logic        rv;
    logic [7:0]  rpc;
    logic        rdy;
    logic        ev;
    logic [7:0]  epc;
    logic [31:0] ein;
    logic [7:0]  ea;
  } vec_t;

  vec_t tbl [14];

  fetch_stage #(.RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .halted         (halted)
  );

  assign imem_instr = mem[imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic rv, logic [7:0] rpc, logic rdy, logic ev, logic [7:0] epc,
                              logic [31:0] ein, logic [7:0] ea);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc; v.ein = ein; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_dpc   = 8'h00;
    m_pc    = 8'h00;
    m_halt  = 1'b0;
  endtask

  // One clock of the fetch rules, stated in terms of the instruction stream.
  task automatic model_step(input logic rv, input logic [7:0] rpc, input logic rdy);
    if (rv) begin
      m_pc    = rpc;
      m_valid = 1'b0;
      m_halt  = 1'b0;
    end else if (!m_halt && (!m_valid || rdy)) begin
`ifdef FETCH_HALT_ON_ZERO_EN
      if (mem[m_pc] == 32'h0) begin
        m_halt  = 1'b1;
        m_valid = 1'b0;
      end else
`endif
      begin
        m_instr = mem[m_pc];
        m_dpc   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 8'd1;
      end
    end else if (m_halt && m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".dec_valid"}, {31'h0, dec_valid}, {31'h0, m_valid});
    chk({tag, ".dec_pc"}, {24'h0, dec_pc}, {24'h0, m_dpc});
    chk({tag, ".dec_instr"}, dec_instr, m_instr);
    chk({tag, ".imem_addr"}, {24'h0, imem_addr}, {24'h0, m_pc});
    chk({tag, ".halted"}, {31'h0, halted}, {31'h0, m_halt});
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic cycle(input logic rv, input logic [7:0] rpc, input logic rdy,
                       input string tag);
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = rdy;
    model_step(rv, rpc, rdy);
    @(negedge clk);
    cmp_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    dec_ready      = 1'b0;
    model_reset();
    #1;
    chk("reset.dec_valid", {31'h0, dec_valid}, 32'h0);
    chk("reset.dec_instr", dec_instr, 32'h0);
    chk("reset.dec_pc", {24'h0, dec_pc}, 32'h0);
    chk("reset.imem_addr", {24'h0, imem_addr}, 32'h0);
    chk("reset.halted", {31'h0, halted}, 32'h0);
    @(negedge clk);
    chk("reset.imem_addr_held", {24'h0, imem_addr}, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    dec_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i + 100);
    model_reset();

    // Streaming, 3-cycle stall at dec_pc=5, redirect under stall.
    for (int i = 0; i < 6; i++)
      tbl[i] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'(i), 32'(100 + i), 8'(i + 1));
    for (int i = 6; i < 9; i++)
      tbl[i] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'd5, 32'd105, 8'd6);
    tbl[9]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'd6, 32'd106, 8'd7);
    tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'd6, 32'd106, 8'd7);
    tbl[11] = mk(1'b1, 8'h40, 1'b0, 1'b0, 8'd6, 32'd106, 8'h40);
    tbl[12] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 32'd164, 8'h41);
    tbl[13] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 32'd164, 8'h41);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].rv, tbl[i].rpc, tbl[i].rdy, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.valid", i), {31'h0, dec_valid}, {31'h0, tbl[i].ev});
      chk($sformatf("tbl%0d.pc", i), {24'h0, dec_pc}, {24'h0, tbl[i].epc});
      chk($sformatf("tbl%0d.instr", i), dec_instr, tbl[i].ein);
      chk($sformatf("tbl%0d.addr", i), {24'h0, imem_addr}, {24'h0, tbl[i].ea});
    end

    // PC wrap FE, FF, 00, 01.
    cycle(1'b1, 8'hFE, 1'b1, "wrap.redir");
    chk("wrap.flush", {31'h0, dec_valid}, 32'h0);
    chk("wrap.addr", {24'h0, imem_addr}, 32'hFE);
    cycle(1'b0, 8'h00, 1'b1, "wrap0");
    chk("wrap0.pc", {24'h0, dec_pc}, 32'hFE);
    cycle(1'b0, 8'h00, 1'b1, "wrap1");
    chk("wrap1.pc", {24'h0, dec_pc}, 32'hFF);
    cycle(1'b0, 8'h00, 1'b1, "wrap2");
    chk("wrap2.pc", {24'h0, dec_pc}, 32'h00);
    cycle(1'b0, 8'h00, 1'b1, "wrap3");
    chk("wrap3.pc", {24'h0, dec_pc}, 32'h01);
    chk("wrap3.valid", {31'h0, dec_valid}, 32'h1);

    // Asynchronous reset in the middle of a cycle while holding an instruction.
    dec_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("areset.dec_valid", {31'h0, dec_valid}, 32'h0);
    chk("areset.imem_addr", {24'h0, imem_addr}, 32'h0);
    chk("areset.dec_instr", dec_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b1, "areset.first");
    chk("areset.first_pc", {24'h0, dec_pc}, 32'h0);
    chk("areset.first_instr", dec_instr, 32'd100);

    // Zero instruction word at address 3.
    mem[3] = 32'h0;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, $sformatf("zero%0d", i));
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("halt.halted", {31'h0, halted}, 32'h1);
    chk("halt.valid", {31'h0, dec_valid}, 32'h0);
    chk("halt.addr", {24'h0, imem_addr}, 32'h3);
    cycle(1'b0, 8'h00, 1'b1, "halt.idle");
    chk("halt.addr_held", {24'h0, imem_addr}, 32'h3);
    cycle(1'b1, 8'h10, 1'b1, "halt.redir");
    chk("halt.cleared", {31'h0, halted}, 32'h0);
    cycle(1'b0, 8'h00, 1'b1, "halt.resume");
    chk("halt.resume_pc", {24'h0, dec_pc}, 32'h10);
    chk("halt.resume_valid", {31'h0, dec_valid}, 32'h1);
`else
    chk("zero.pc", {24'h0, dec_pc}, 32'h3);
    chk("zero.instr", dec_instr, 32'h0);
    chk("zero.valid", {31'h0, dec_valid}, 32'h1);
    chk("zero.halted", {31'h0, halted}, 32'h0);
`endif

    // Random traffic against the model; some zero words and frequent redirects.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(15) == 0) ? 32'h0 : $urandom;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic rv;
      rv = ($urandom_range(9) == 0);
      cycle(rv, 8'($urandom), 1'($urandom_range(3) != 0), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 8'h00, PC value loaded at reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: imem_addr  output  8  address to the combinational instruction memory; equals the PC register.
REQ-005 SHALL have port: imem_instr  input  32  instruction read at imem_addr in the same cycle.
REQ-006 SHALL have port: redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port: redirect_pc  input  8  redirect target, sampled when redirect_valid=1.
REQ-008 SHALL have port: dec_valid  output  1  IF/ID register holds a valid instruction.
REQ-009 SHALL have port: dec_ready  input  1  decode accepts dec_* this cycle.
REQ-010 SHALL have port: dec_instr  output  32  registered instruction.
REQ-011 SHALL have port: dec_pc  output  8  address dec_instr was fetched from.
REQ-012 SHALL have port: halted  output  1  fetch stopped on halt word; constant 0 when the feature is compiled out.

Function
REQ-013 SHALL hold an 8-bit PC register and a registered IF/ID output (dec_valid, dec_instr, dec_pc); no combinational path from imem_instr to dec_*.
REQ-014 SHALL define "advance" = (!dec_valid || dec_ready) && !redirect_valid && state==RUN.
REQ-015 On advance: dec_instr<=imem_instr, dec_pc<=PC, dec_valid<=1, PC<=PC+1.
REQ-016 PC increment SHALL be modulo 256; 8'hFF advances to 8'h00 without a flag.
REQ-017 Latency SHALL be 1 cycle: instruction at address A appears on dec_* the cycle after PC==A with advance true.
REQ-018 When dec_valid=1 and dec_ready=0 (and no redirect): PC, dec_instr, dec_pc, dec_valid SHALL hold unchanged.
REQ-019 dec_valid=1 with dec_ready=1 and advance: back-to-back transfer, one instruction per cycle, no bubble.
REQ-020 dec_valid=1 with dec_ready=1 and no new fetch (HALT state): dec_valid<=0.
REQ-021 redirect_valid=1 SHALL take priority over everything: PC<=redirect_pc, dec_valid<=0 (flush, independent of dec_ready), state<=RUN; no fetch in that cycle.
REQ-022 First instruction after a redirect SHALL appear on dec_* exactly 2 cycles after the redirect edge's cycle (redirect cycle, then fetch cycle).
REQ-023 FSM states: RUN (fetching), HALT (not fetching); RUN->HALT only per REQ-028; HALT->RUN only on redirect_valid.
REQ-024 dec_instr and dec_pc SHALL be don't-care-stable (hold last value) while dec_valid=0.

Reset
REQ-025 rst_n low SHALL immediately (asynchronously) set PC=RESET_PC, dec_valid=0, dec_instr=32'h0, dec_pc=8'h00, state=RUN, halted=0.
REQ-026 Reset mid-transfer SHALL drop any held instruction; after rst_n rises, the first advance fetches RESET_PC.
REQ-027 imem_addr SHALL equal RESET_PC throughout reset.

Configuration
REQ-028 With FETCH_HALT_ON_ZERO_EN defined: an advance where imem_instr==32'h0 SHALL not load the IF/ID register nor increment PC; state<=HALT, halted<=1 next cycle; dec_valid follows REQ-020; redirect clears halted and resumes.
REQ-029 Without FETCH_HALT_ON_ZERO_EN: 32'h0 is an ordinary instruction, HALT is unreachable, halted is tied 0.

Verification
REQ-030 Reset release, dec_ready=1, memory[i]=i+100 -> dec_pc 0,1,2,... on consecutive cycles from cycle 1, dec_instr=100,101,...
REQ-031 dec_ready=0 for 3 cycles with dec_valid=1 at dec_pc=5 -> dec_pc/dec_instr/imem_addr frozen (5 / mem[5] / 6), resume at 6 with no loss or duplicate.
REQ-032 redirect_valid=1, redirect_pc=8'h40 while dec_valid=1, dec_ready=0 -> next cycle dec_valid=0, imem_addr=8'h40; following cycle dec_pc=8'h40.
REQ-033 PC at 8'hFE, dec_ready=1 -> dec_pc sequence FE, FF, 00, 01.
REQ-034 FETCH_HALT_ON_ZERO_EN defined, mem[3]=0 -> dec_pc 0,1,2 delivered, halted=1, dec_valid=0, imem_addr held 3; redirect to 8'h10 -> halted=0, dec_pc=8'h10 two cycles later.
REQ-035 rst_n asserted asynchronously mid-cycle with dec_valid=1 -> dec_valid=0 and imem_addr=RESET_PC before the next clock edge.
